// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin bus arbiter.
package wb_arb_pkg;

    // Arbiter FSM states: no owner, owner locked for its cycle, owner aborted by the watchdog.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        ABORT = 2'd2
    } arb_state_t;

    // Binary index of the set bit in a one-hot vector (0 when the vector is empty).
    function automatic int onehot2idx(input logic [31:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request found scanning upward from the
// slot after the previous winner, wrapping modulo NUMM. The previous winner is
// scanned last, so it only wins again when nobody else is asking.
module rr_pick
    import wb_arb_pkg::*;
#(
    parameter int NUMM = 3,
    localparam int IDXW = $clog2(NUMM)
) (
    input  logic [NUMM-1:0] i_req,
    input  logic [IDXW-1:0] i_last,
    output logic [IDXW-1:0] o_win,
    output logic            o_valid
);

    // Scan offsets 1..NUMM from the previous winner; the first hit wins.
    always_comb begin
        int j;
        // NOTE: every output gets a default before any conditional assignment, so no latch is inferred.
        o_win   = '0;
        o_valid = 1'b0;
        j       = 0;
        for (int off = 1; off <= NUMM; off++) begin
            j = int'(i_last) + off;
            if (j >= NUMM) j = j - NUMM;
            if (!o_valid && i_req[j]) begin
                o_valid = 1'b1;
                o_win   = IDXW'(j);
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Grant controller for the shared Wishbone bus. Ownership is held for the whole
// cyc of the winning master; a watchdog aborts slaves that stall the owner.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUMM    = 3,
    parameter int TIMEOUT = 1023,
    parameter bit PRIO_M0 = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUMM-1:0]         cyc_i,
    input  logic [NUMM-1:0]         stb_i,
    input  logic                    ack_i,
    input  logic                    err_i,
    output logic [NUMM-1:0]         gnt_o,
    output logic [$clog2(NUMM)-1:0] gnt_idx_o,
    output logic                    busy_o,
    output logic                    timeout_err_o
);

    localparam int IDXW = $clog2(NUMM);
    // A zero TIMEOUT disables the watchdog; keep the counter one bit wide then.
    localparam int WDW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t      r_state;
    logic [NUMM-1:0] r_gnt;
    logic [IDXW-1:0] r_last;
    logic [WDW-1:0]  r_wdog;
    logic            r_tout;

    logic [IDXW-1:0] w_rr_idx;
    logic            w_rr_valid;
    logic [IDXW-1:0] w_win_idx;
    logic            w_win_valid;
    logic [NUMM-1:0] w_win_oh;
    logic            w_own_cyc;
    logic            w_own_stb;
    logic [WDW-1:0]  w_wdog_next;
    logic            w_wdog_hit;

    rr_pick #(
        .NUMM (NUMM)
    ) u_pick (
        .i_req   (cyc_i),
        .i_last  (r_last),
        .o_win   (w_rr_idx),
        .o_valid (w_rr_valid)
    );

    // m0 overrides the rotation when fixed priority is enabled and it is requesting.
    always_comb begin
        w_win_idx   = w_rr_idx;
        w_win_valid = w_rr_valid;
        if (PRIO_M0 && cyc_i[0]) begin
            w_win_idx   = '0;
            w_win_valid = 1'b1;
        end
    end

    assign w_win_oh  = NUMM'(1) << w_win_idx;
    assign w_own_cyc = |(cyc_i & r_gnt);
    assign w_own_stb = |(stb_i & r_gnt);

    // Watchdog next value: cleared by any slave response or an idle strobe, otherwise saturating count.
    always_comb begin
        w_wdog_next = r_wdog;
        if (ack_i || err_i || !w_own_stb) begin
            w_wdog_next = '0;
        end else if (r_wdog != WDW'(TIMEOUT)) begin
            w_wdog_next = r_wdog + WDW'(1);
        end
    end

    assign w_wdog_hit = (TIMEOUT != 0) && (w_wdog_next == WDW'(TIMEOUT));

    // Arbiter FSM: grant, hold for the owner's cycle, re-arbitrate on release, abort on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_last  <= IDXW'(NUMM - 1);
            r_wdog  <= '0;
            r_tout  <= 1'b0;
        end else begin
            // NOTE: state flops use non-blocking assignment so every read in this block sees the pre-edge value.
            r_tout <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_wdog <= '0;
                    if (w_win_valid) begin
                        r_gnt   <= w_win_oh;
                        r_last  <= w_win_idx;
                        r_state <= OWN;
                    end
                end
                OWN, ABORT: begin
                    if (!w_own_cyc) begin
                        // Release beats a watchdog hit in the same cycle.
                        r_wdog <= '0;
                        if (w_win_valid) begin
                            r_gnt   <= w_win_oh;
                            r_last  <= w_win_idx;
                            r_state <= OWN;
                        end else begin
                            r_gnt   <= '0;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_wdog <= w_wdog_next;
                        if (r_state == OWN && w_wdog_hit) begin
                            r_state <= ABORT;
                            r_tout  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt_o         = r_gnt;
    assign gnt_idx_o     = IDXW'(onehot2idx(32'(r_gnt)));
    assign busy_o        = |r_gnt;
    assign timeout_err_o = r_tout;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench for wb_rr_arbiter. Stimulus queues the expected grant/abort
// events with the cycle they must appear in; monitors pop and compare whenever
// a DUT changes its grant or raises timeout_err_o.
module tb_wb_rr_arbiter;

    typedef struct {
        int         cyc;
        logic [2:0] gnt;
        logic [1:0] idx;
        logic       tout;
        string      name;
    } ev_t;

    logic       clk;
    logic       rst;
    // dut_a: pure round-robin, short watchdog
    logic [2:0] cyc_a, stb_a;
    logic       ack_a, err_a;
    logic [2:0] gnt_a;
    logic [1:0] idx_a;
    logic       busy_a, tout_a;
    // dut_b: m0 fixed priority
    logic [2:0] cyc_b, stb_b;
    logic       ack_b, err_b;
    logic [2:0] gnt_b;
    logic [1:0] idx_b;
    logic       busy_b, tout_b;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc_cnt  = 0;
    bit  mon_en   = 1'b0;
    logic [2:0] prev_a = 3'b000;
    logic [2:0] prev_b = 3'b000;
    ev_t q_a[$];
    ev_t q_b[$];
    ev_t e_a, e_b;

    logic [2:0] ord_g [4];
    logic [1:0] ord_i [4];

    wb_rr_arbiter #(.NUMM(3), .TIMEOUT(8), .PRIO_M0(1'b0)) dut_a (
        .clk           (clk),
        .rst           (rst),
        .cyc_i         (cyc_a),
        .stb_i         (stb_a),
        .ack_i         (ack_a),
        .err_i         (err_a),
        .gnt_o         (gnt_a),
        .gnt_idx_o     (idx_a),
        .busy_o        (busy_a),
        .timeout_err_o (tout_a)
    );

    wb_rr_arbiter #(.NUMM(3), .TIMEOUT(8), .PRIO_M0(1'b1)) dut_b (
        .clk           (clk),
        .rst           (rst),
        .cyc_i         (cyc_b),
        .stb_i         (stb_b),
        .ack_i         (ack_b),
        .err_i         (err_b),
        .gnt_o         (gnt_b),
        .gnt_idx_o     (idx_b),
        .busy_o        (busy_b),
        .timeout_err_o (tout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // {cycle[15:0], gnt, idx, busy, tout}
    function automatic logic [31:0] pack(input int c, input logic [2:0] g, input logic [1:0] i,
                                         input logic b, input logic t);
        logic [31:0] cc;
        cc = c;
        return {9'd0, cc[15:0], g, i, b, t};
    endfunction

    task automatic expect_ev(input bit on_b, input int dly, input logic [2:0] g, input logic [1:0] i,
                             input logic t, input string nm);
        ev_t e;
        e.cyc  = cyc_cnt + dly;
        e.gnt  = g;
        e.idx  = i;
        e.tout = t;
        e.name = nm;
        if (on_b) q_b.push_back(e);
        else      q_a.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for dut_a
    always @(negedge clk) begin
        if (mon_en) begin
            if (gnt_a !== prev_a || tout_a !== 1'b0) begin
                if (q_a.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL a_unexpected_event: cycle=%0d gnt=%b tout=%b, required no event",
                             cyc_cnt, gnt_a, tout_a);
                end else begin
                    e_a = q_a.pop_front();
                    check({"a_", e_a.name}, pack(cyc_cnt, gnt_a, idx_a, busy_a, tout_a),
                          pack(e_a.cyc, e_a.gnt, e_a.idx, |e_a.gnt, e_a.tout));
                end
            end
            prev_a = gnt_a;
        end
    end

    // Monitor for dut_b
    always @(negedge clk) begin
        if (mon_en) begin
            if (gnt_b !== prev_b || tout_b !== 1'b0) begin
                if (q_b.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL b_unexpected_event: cycle=%0d gnt=%b tout=%b, required no event",
                             cyc_cnt, gnt_b, tout_b);
                end else begin
                    e_b = q_b.pop_front();
                    check({"b_", e_b.name}, pack(cyc_cnt, gnt_b, idx_b, busy_b, tout_b),
                          pack(e_b.cyc, e_b.gnt, e_b.idx, |e_b.gnt, e_b.tout));
                end
            end
            prev_b = gnt_b;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "time limit");
    end

    initial begin
        ord_g[0] = 3'b001; ord_i[0] = 2'd0;
        ord_g[1] = 3'b010; ord_i[1] = 2'd1;
        ord_g[2] = 3'b100; ord_i[2] = 2'd2;
        ord_g[3] = 3'b001; ord_i[3] = 2'd0;

        rst = 1'b1;
        cyc_a = '0; stb_a = '0; ack_a = 1'b0; err_a = 1'b0;
        cyc_b = '0; stb_b = '0; ack_b = 1'b0; err_b = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_gnt_a",  32'(gnt_a),  32'd0);
        check("rst_idx_a",  32'(idx_a),  32'd0);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_tout_a", 32'(tout_a), 32'd0);
        check("rst_gnt_b",  32'(gnt_b),  32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        tick();

        // 1: single owner m1, held across 4 acks, release to idle
        cyc_a = 3'b010; stb_a = 3'b010;
        expect_ev(0, 1, 3'b010, 2'd1, 1'b0, "t1_grant_m1");
        tick();
        ack_a = 1'b1;
        repeat (4) tick();
        ack_a = 1'b0;
        tick();
        cyc_a = 3'b000; stb_a = 3'b000;
        expect_ev(0, 1, 3'b000, 2'd0, 1'b0, "t1_release_idle");
        tick();

        // Fresh round-robin pointer for the fairness run
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // 2: fairness m0,m1,m2,m0 back-to-back
        cyc_a = 3'b111; stb_a = 3'b111;
        expect_ev(0, 1, ord_g[0], ord_i[0], 1'b0, "t2_grant_0");
        tick();
        for (int k = 0; k < 4; k++) begin
            ack_a = 1'b1;
            tick();
            ack_a = 1'b0;
            if (k < 3) begin
                cyc_a = 3'b111 & ~ord_g[k];
                expect_ev(0, 1, ord_g[k+1], ord_i[k+1], 1'b0, $sformatf("t2_grant_%0d", k + 1));
                tick();
                cyc_a = 3'b111;
            end else begin
                cyc_a = 3'b000; stb_a = 3'b000;
                expect_ev(0, 1, 3'b000, 2'd0, 1'b0, "t2_idle");
                tick();
            end
        end

        // 4a: m2 stalls -> single pulse 8 cycles after the first stalled cycle, grant held
        cyc_a = 3'b100; stb_a = 3'b100;
        expect_ev(0, 1, 3'b100, 2'd2, 1'b0, "t4_grant_m2");
        expect_ev(0, 9, 3'b100, 2'd2, 1'b1, "t4_timeout_pulse");
        tick();
        repeat (10) tick();
        cyc_a = 3'b000; stb_a = 3'b000;
        expect_ev(0, 1, 3'b000, 2'd0, 1'b0, "t4_release_after_abort");
        tick();

        // 4b: ack on 7th stalled cycle, then err at the limit cycle -> no pulse
        cyc_a = 3'b100; stb_a = 3'b100;
        expect_ev(0, 1, 3'b100, 2'd2, 1'b0, "t4b_grant_m2");
        tick();
        repeat (6) tick();
        ack_a = 1'b1;
        tick();
        ack_a = 1'b0;
        repeat (7) tick();
        err_a = 1'b1;
        tick();
        err_a = 1'b0;
        repeat (2) tick();
        cyc_a = 3'b000; stb_a = 3'b000;
        expect_ev(0, 1, 3'b000, 2'd0, 1'b0, "t4b_release_no_pulse");
        tick();

        // 6: owner m0 drops cyc in the limit cycle while m1 requests -> no pulse, m1 next
        cyc_a = 3'b001; stb_a = 3'b001;
        expect_ev(0, 1, 3'b001, 2'd0, 1'b0, "t6_grant_m0");
        tick();
        cyc_a = 3'b011; stb_a = 3'b011;
        repeat (7) tick();
        cyc_a = 3'b010; stb_a = 3'b010;
        expect_ev(0, 1, 3'b010, 2'd1, 1'b0, "t6_release_wins_m1");
        tick();
        cyc_a = 3'b000; stb_a = 3'b000;
        expect_ev(0, 1, 3'b000, 2'd0, 1'b0, "t6_idle");
        tick();

        // 5: rst during an m2 burst, then everyone requests -> m0 first
        cyc_a = 3'b100; stb_a = 3'b100;
        expect_ev(0, 1, 3'b100, 2'd2, 1'b0, "t5_grant_m2");
        tick();
        ack_a = 1'b1;
        repeat (2) tick();
        ack_a = 1'b0;
        rst = 1'b1;
        cyc_a = 3'b111; stb_a = 3'b111;
        expect_ev(0, 1, 3'b000, 2'd0, 1'b0, "t5_rst_clears");
        tick();
        rst = 1'b0;
        expect_ev(0, 1, 3'b001, 2'd0, 1'b0, "t5_first_after_rst_m0");
        tick();
        cyc_a = 3'b000; stb_a = 3'b000;
        expect_ev(0, 1, 3'b000, 2'd0, 1'b0, "t5_idle");
        tick();

        // 3: PRIO_M0=1, m1 owns, m0 and m2 pending -> m0 then m2
        cyc_b = 3'b010;
        expect_ev(1, 1, 3'b010, 2'd1, 1'b0, "t3_grant_m1");
        tick();
        cyc_b = 3'b111;
        repeat (2) tick();
        cyc_b = 3'b101;
        expect_ev(1, 1, 3'b001, 2'd0, 1'b0, "t3_prio_m0");
        tick();
        cyc_b = 3'b100;
        expect_ev(1, 1, 3'b100, 2'd2, 1'b0, "t3_then_m2");
        tick();
        cyc_b = 3'b000;
        expect_ev(1, 1, 3'b000, 2'd0, 1'b0, "t3_idle");
        tick();

        repeat (3) tick();
        check("a_events_drained", 32'(q_a.size()), 32'd0);
        check("b_events_drained", 32'(q_b.size()), 32'd0);
        while (q_a.size() > 0) begin
            e_a = q_a.pop_front();
            $display("FAIL a_missing_%s: no event seen, required cycle %0d", e_a.name, e_a.cyc);
        end
        while (q_b.size() > 0) begin
            e_b = q_b.pop_front();
            $display("FAIL b_missing_%s: no event seen, required cycle %0d", e_b.name, e_b.cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
